alu_mdu: RTL and testbench
==========================

# alu_mdu

Parametrised execution unit for the pipelined CPU's EX stage. It combines a single-cycle combinational ALU (add/sub/logic/shift/LUI/SLT with zero and overflow flags) with an iterative multiply/divide unit (MDU). The MDU computes one bit per cycle and owns the HI/LO register pair. The pipeline stalls on `busy` and reads results from `hi`/`lo`.

## Interface
- `WIDTH`, default 32: datapath width; must be even and a power of two, ≥ 8.
- `SHW`, default $clog2(WIDTH): shift-amount width (derived; do not override).

Ports:
- `clock`  in  1  system clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high.
- `a`  in  WIDTH  operand A; shift amount is `a[SHW-1:0]` for shifts.
- `b`  in  WIDTH  operand B.
- `aluc`  in  4  ALU opcode.
- `s`  out  WIDTH  ALU result (combinational).
- `z`  out  1  1 when `s == 0` (combinational).
- `v`  out  1  signed overflow of ADD/SUB; 0 for every other opcode.
- `md_start`  in  1  request an MDU operation using current `a`, `b`, `md_op`.
- `md_op`  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- `busy`  out  1  MDU operation in progress.
- `done`  out  1  one-cycle pulse when `hi`/`lo` hold the new result.
- `hi`  out  WIDTH  MULT: upper product; DIV: remainder.
- `lo`  out  WIDTH  MULT: lower product; DIV: quotient.

## Operation
ALU opcodes (`x` = don't care):
- x000 ADD; x100 SUB; x001 AND; x101 OR; x010 XOR.
- x110 LUI: `b << WIDTH/2`.
- 0011 SLL: `b << a[SHW-1:0]`; 0111 SRL logical; 1111 SRA arithmetic.
- 1011 SLT: signed `a < b` → 1, else 0.
- All others: `s = 0`.
- `v` is set for x000/x100 when operand signs and result sign indicate signed overflow.

MDU state machine, states IDLE, RUN, FIX:
- IDLE: `md_start=1` latches `a`, `b`, `md_op`.
  - Signed ops store magnitudes and record the result signs.
  - Divisor 0 on DIV/DIVU → FIX directly.
  - Otherwise → RUN with the iteration counter at WIDTH-1.
- RUN: one shift-add (multiply) or restoring shift-subtract (divide) step per cycle. → FIX when the counter reaches 0, i.e. exactly WIDTH RUN cycles.
- FIX: apply sign correction, write `hi`/`lo`, assert `done` next cycle, → IDLE.
- Signed divide: quotient sign = sign(a) XOR sign(b); remainder sign = sign(a).
- Divide by zero: `hi = a`, `lo` = all ones; no trap.
- DIV of most-negative by -1: `lo` = most-negative, `hi = 0`; no trap.
- `md_start` while `busy=1`: ignored; latched operands are unaffected.
- `md_start` in the cycle `done=1`: accepted (the FSM is in IDLE).
- `hi`/`lo` change only on the edge that raises `done`; they hold otherwise.
- `reset` in any state → IDLE; the in-flight operation is discarded.

## Timing
- ALU path: purely combinational, zero latency, independent of MDU state.
- `md_start` sampled at edge 0:
  - `busy=1` in cycles 1..WIDTH+1.
  - `done=1` and new `hi`/`lo` in cycle WIDTH+2, with `busy=0`.
  - Normal latency: WIDTH+2 cycles (34 for WIDTH=32).
- Divide by zero: `busy=1` in cycle 1 only; `done` in cycle 2.
- Reset values: `busy=0`, `done=0`, `hi=0`, `lo=0`, state IDLE. `s`/`z`/`v` follow the inputs.
- `done` is registered and never high for two consecutive cycles.

## Structure
- Package `alu_pkg`:
  - `aluc` opcode localparams (ADD, SUB, AND, OR, XOR, LUI, SLL, SRL, SRA, SLT).
  - `md_op` encodings.
  - MDU state enum.
- Sub-module `mdu_iter`: contains the FSM, counter, partial-product/remainder registers, sign fix-up, `hi`/`lo`, `busy` and `done`.
- `alu_mdu` instantiates `mdu_iter` and holds the combinational ALU.

## Test plan
- ALU sweep, WIDTH=32:
  - ADD 0x7FFFFFFF+1 → s=0x80000000, v=1.
  - SUB 5-5 → s=0, z=1, v=0.
  - SRA 0x80000000 by 4 → 0xF8000000.
  - LUI b=0x1234 → 0x12340000.
  - SLT -1<1 → 1.
- MULT a=-3, b=7 → done at cycle 34; hi=0xFFFFFFFF, lo=0xFFFFFFEB. MULTU 0xFFFFFFFF² → hi=0xFFFFFFFE, lo=1.
- DIV a=-7, b=2 → lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). DIVU 100/7 → lo=14, hi=2.
- DIVU a=9, b=0 → done at cycle 2; hi=9, lo=0xFFFFFFFF.
- `md_start` pulsed mid-RUN with new operands → ignored, original result returned. Back-to-back start on the done cycle → second done exactly 34 cycles later.
- `reset` asserted at cycle 10 of a MULT → next cycle busy=0, done=0, hi=lo=0; no done pulse follows.
- Parameter run WIDTH=16: MULTU 0xFFFF×2 → hi=1, lo=0xFFFE, done at cycle 18.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared encodings for the EX-stage ALU and the iterative multiply/divide unit.
package alu_pkg;

   // aluc opcodes; bit 3 is a don't-care except on the shift/compare group
   localparam logic [3:0] ALUC_ADD = 4'b0000;
   localparam logic [3:0] ALUC_SUB = 4'b0100;
   localparam logic [3:0] ALUC_AND = 4'b0001;
   localparam logic [3:0] ALUC_OR  = 4'b0101;
   localparam logic [3:0] ALUC_XOR = 4'b0010;
   localparam logic [3:0] ALUC_LUI = 4'b0110;
   localparam logic [3:0] ALUC_SLL = 4'b0011;
   localparam logic [3:0] ALUC_SRL = 4'b0111;
   localparam logic [3:0] ALUC_SRA = 4'b1111;
   localparam logic [3:0] ALUC_SLT = 4'b1011;

   // md_op encodings: bit 0 = unsigned, bit 1 = divide
   localparam logic [1:0] MD_MULT  = 2'b00;
   localparam logic [1:0] MD_MULTU = 2'b01;
   localparam logic [1:0] MD_DIV   = 2'b10;
   localparam logic [1:0] MD_DIVU  = 2'b11;

   typedef enum logic [1:0] {
      MD_IDLE = 2'd0,
      MD_RUN  = 2'd1,
      MD_FIX  = 2'd2
   } md_state_t;

endpackage

// File: rtl/mdu_iter.sv
// Iterative multiply/divide unit: one bit per cycle, owns the HI/LO pair.
//
// state   | meaning
// --------+---------------------------------------------------------------
// MD_IDLE | waiting for i_start; operands latched as magnitudes on start
// MD_RUN  | one shift-add / restoring shift-subtract step per cycle
// MD_FIX  | sign fix-up, write HI/LO, raise done on the following cycle
module mdu_iter
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   input  logic             i_start,
   input  logic [1:0]       i_op,
   output logic             o_busy,
   output logic             o_done,
   output logic [WIDTH-1:0] o_hi,
   output logic [WIDTH-1:0] o_lo
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] CNT_TOP = CW'(WIDTH - 1);
   localparam logic [CW-1:0] CNT_ONE = CW'(1);

   md_state_t          r_state;
   logic [CW-1:0]      r_cnt;
   logic [WIDTH-1:0]   r_b;
   logic [WIDTH-1:0]   r_rem;
   logic [WIDTH-1:0]   r_q;
   logic               r_div;
   logic               r_dz;
   logic               r_neg_q;
   logic               r_neg_r;
   logic               r_done;
   logic [WIDTH-1:0]   r_hi;
   logic [WIDTH-1:0]   r_lo;

   logic               w_signed;
   logic               w_neg_a;
   logic               w_neg_b;
   logic [WIDTH-1:0]   w_mag_a;
   logic [WIDTH-1:0]   w_mag_b;
   logic [WIDTH:0]     w_mul_sum;
   logic [WIDTH:0]     w_div_sh;
   logic               w_div_ge;
   logic [WIDTH-1:0]   w_div_diff;
   logic [2*WIDTH-1:0] w_prod;
   logic [2*WIDTH-1:0] w_prod_fix;
   logic [WIDTH-1:0]   w_q_fix;
   logic [WIDTH-1:0]   w_r_fix;

   assign w_signed = ~i_op[0];
   assign w_neg_a  = w_signed & i_a[WIDTH-1];
   assign w_neg_b  = w_signed & i_b[WIDTH-1];
   assign w_mag_a  = w_neg_a ? -i_a : i_a;
   assign w_mag_b  = w_neg_b ? -i_b : i_b;

   // r_rem:r_q is the running product (multiply) or remainder:dividend/quotient (divide)
   assign w_mul_sum  = {1'b0, r_rem} + (r_q[0] ? {1'b0, r_b} : '0);
   assign w_div_sh   = {r_rem, r_q[WIDTH-1]};
   assign w_div_ge   = w_div_sh >= {1'b0, r_b};
   // only used when w_div_ge, so the true difference fits in WIDTH bits
   assign w_div_diff = w_div_sh[WIDTH-1:0] - r_b;

   assign w_prod     = {r_rem, r_q};
   assign w_prod_fix = r_neg_q ? -w_prod : w_prod;
   assign w_q_fix    = r_neg_q ? -r_q : r_q;
   assign w_r_fix    = r_neg_r ? -r_rem : r_rem;

   // MDU sequencer, datapath registers and HI/LO result write
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= MD_IDLE;
         r_cnt   <= '0;
         r_b     <= '0;
         r_rem   <= '0;
         r_q     <= '0;
         r_div   <= 1'b0;
         r_dz    <= 1'b0;
         r_neg_q <= 1'b0;
         r_neg_r <= 1'b0;
         r_done  <= 1'b0;
         r_hi    <= '0;
         r_lo    <= '0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            MD_IDLE: begin
               if (i_start) begin
                  r_div   <= i_op[1];
                  r_b     <= w_mag_b;
                  r_neg_q <= w_neg_a ^ w_neg_b;
                  r_neg_r <= w_neg_a;
                  if (i_op[1] && (i_b == '0)) begin
                     // divide by zero: result is known, skip the iterations
                     r_dz    <= 1'b1;
                     r_rem   <= i_a;
                     r_q     <= '1;
                     r_state <= MD_FIX;
                  end else begin
                     r_dz    <= 1'b0;
                     r_rem   <= '0;
                     r_q     <= w_mag_a;
                     r_cnt   <= CNT_TOP;
                     r_state <= MD_RUN;
                  end
               end
            end
            MD_RUN: begin
               if (r_div) begin
                  r_rem <= w_div_ge ? w_div_diff : w_div_sh[WIDTH-1:0];
                  r_q   <= {r_q[WIDTH-2:0], w_div_ge};
               end else begin
                  r_rem <= w_mul_sum[WIDTH:1];
                  r_q   <= {w_mul_sum[0], r_q[WIDTH-1:1]};
               end
               if (r_cnt == '0) begin
                  r_state <= MD_FIX;
               end else begin
                  r_cnt <= r_cnt - CNT_ONE;
               end
            end
            MD_FIX: begin
               if (r_dz) begin
                  r_hi <= r_rem;
                  r_lo <= r_q;
               end else if (r_div) begin
                  r_hi <= w_r_fix;
                  r_lo <= w_q_fix;
               end else begin
                  r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
                  r_lo <= w_prod_fix[WIDTH-1:0];
               end
               r_done  <= 1'b1;
               r_state <= MD_IDLE;
            end
            default: r_state <= MD_IDLE;
         endcase
      end
   end

   assign o_busy = (r_state != MD_IDLE);
   assign o_done = r_done;
   assign o_hi   = r_hi;
   assign o_lo   = r_lo;

endmodule

// File: rtl/alu_mdu.sv
// EX-stage execution unit: combinational ALU plus iterative multiply/divide.
module alu_mdu
   import alu_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [3:0]       aluc,
   output logic [WIDTH-1:0] s,
   output logic             z,
   output logic             v,
   input  logic             md_start,
   input  logic [1:0]       md_op,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   logic [WIDTH-1:0] w_sum;
   logic [WIDTH-1:0] w_diff;
   logic [SHW-1:0]   w_shamt;
   logic             w_lt;
   logic [WIDTH-1:0] w_s;
   logic             w_v;

   assign w_sum   = a + b;
   assign w_diff  = a - b;
   assign w_shamt = a[SHW-1:0];
   assign w_lt    = $signed(a) < $signed(b);

   // ALU result and ADD/SUB signed overflow; bit 3 only matters for the shift/SLT group
   always_comb begin
      w_s = '0;
      w_v = 1'b0;
      case (aluc[2:0])
         ALUC_ADD[2:0]: begin
            w_s = w_sum;
            w_v = (a[WIDTH-1] == b[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
         end
         ALUC_SUB[2:0]: begin
            w_s = w_diff;
            w_v = (a[WIDTH-1] != b[WIDTH-1]) && (w_diff[WIDTH-1] != a[WIDTH-1]);
         end
         ALUC_AND[2:0]: w_s = a & b;
         ALUC_OR[2:0]:  w_s = a | b;
         ALUC_XOR[2:0]: w_s = a ^ b;
         ALUC_LUI[2:0]: w_s = b << (WIDTH / 2);
         ALUC_SLL[2:0]: begin
            if (aluc == ALUC_SLT) w_s = {{(WIDTH-1){1'b0}}, w_lt};
            else                  w_s = b << w_shamt;
         end
         ALUC_SRL[2:0]: begin
            if (aluc == ALUC_SRA) w_s = $unsigned($signed(b) >>> w_shamt);
            else                  w_s = b >> w_shamt;
         end
         default: w_s = '0;
      endcase
   end

   assign s = w_s;
   assign z = (w_s == '0);
   assign v = w_v;

   mdu_iter #(
      .WIDTH (WIDTH)
   ) u_mdu (
      .i_clk   (clock),
      .i_rst   (reset),
      .i_a     (a),
      .i_b     (b),
      .i_start (md_start),
      .i_op    (md_op),
      .o_busy  (busy),
      .o_done  (done),
      .o_hi    (hi),
      .o_lo    (lo)
   );

endmodule

// File: tb/tb_alu_mdu.sv
// Bench for alu_mdu: directed ALU vectors plus a queued scoreboard for MDU results.
module tb_alu_mdu;

   localparam int W = 32;
   localparam int LAT_NORM = W + 1;   // cyc distance from sampling edge to done cycle
   localparam int LAT_DZ   = 1;

   logic          clock = 1'b0;
   logic          reset;
   logic [W-1:0]  a, b, s, hi, lo;
   logic [3:0]    aluc;
   logic          z, v, md_start, busy, done;
   logic [1:0]    md_op;

   logic [15:0]   a16, b16, s16, hi16, lo16;
   logic [3:0]    aluc16;
   logic          z16, v16, md_start16, busy16, done16;
   logic [1:0]    md_op16;

   alu_mdu #(.WIDTH(W)) dut (
      .clock(clock), .reset(reset), .a(a), .b(b), .aluc(aluc),
      .s(s), .z(z), .v(v), .md_start(md_start), .md_op(md_op),
      .busy(busy), .done(done), .hi(hi), .lo(lo)
   );

   alu_mdu #(.WIDTH(16)) dut16 (
      .clock(clock), .reset(reset), .a(a16), .b(b16), .aluc(aluc16),
      .s(s16), .z(z16), .v(v16), .md_start(md_start16), .md_op(md_op16),
      .busy(busy16), .done(done16), .hi(hi16), .lo(lo16)
   );

   always #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   int n_checks = 0;
   int n_errors = 0;
   int n_done   = 0;

   typedef struct {
      logic [W-1:0] hi;
      logic [W-1:0] lo;
      int           at;
      string        name;
   } exp_t;
   exp_t sb[$];

   typedef struct {
      logic [3:0]   op;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] s;
      logic         z;
      logic         v;
      string        name;
   } alu_vec_t;

   typedef struct {
      logic [1:0]   op;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] hi;
      logic [W-1:0] lo;
      int           lat;
      string        name;
   } md_vec_t;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, wanted 0x%0h", name, act, exp);
      end
   endtask

   task automatic fail(input string name);
      n_checks++;
      n_errors++;
      $display("FAIL %s", name);
   endtask

   // drive a start request for one edge; optionally queue the expected result
   task automatic issue(input logic [1:0] op, input logic [W-1:0] ia, input logic [W-1:0] ib,
                        input logic [W-1:0] eh, input logic [W-1:0] el, input int lat,
                        input string name, input bit push);
      md_op    = op;
      a        = ia;
      b        = ib;
      md_start = 1'b1;
      @(posedge clock);
      #1;
      md_start = 1'b0;
      if (push) sb.push_back('{eh, el, cyc + lat, name});
   endtask

   task automatic wait_drain(input string name);
      for (int i = 0; i < 200 && sb.size() != 0; i++) begin
         @(posedge clock);
         #1;
      end
      if (sb.size() != 0) begin
         fail({name, "_timeout"});
         sb.delete();
      end
   endtask

   // monitor: every done pulse must match the oldest queued expectation
   initial begin : monitor
      bit   prev_done;
      exp_t e;
      prev_done = 1'b0;
      forever begin
         @(negedge clock);
         if (reset) begin
            prev_done = 1'b0;
         end else begin
            if (done) begin
               n_done++;
               check("done_single_pulse", 64'(prev_done), 64'd0);
               check("busy_low_at_done", 64'(busy), 64'd0);
               if (sb.size() == 0) begin
                  fail("unexpected_done");
               end else begin
                  e = sb.pop_front();
                  check({e.name, "_hi"}, 64'(hi), 64'(e.hi));
                  check({e.name, "_lo"}, 64'(lo), 64'(e.lo));
                  check({e.name, "_cycle"}, 64'(cyc), 64'(e.at));
               end
            end
            prev_done = done;
         end
      end
   end

   alu_vec_t av[15];
   md_vec_t  mv[9];
   int       c0;
   int       done_snap;

   initial begin
      av = '{
         '{4'b0000, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b1, "add_ovf"},
         '{4'b0100, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 1'b1, 1'b0, "sub_zero"},
         '{4'b0100, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b0, 1'b1, "sub_ovf"},
         '{4'b1000, 32'h0000_0002, 32'h0000_0003, 32'h0000_0005, 1'b0, 1'b0, "add_alt"},
         '{4'b0001, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000, 1'b0, 1'b0, "and"},
         '{4'b0101, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_FFF0, 1'b0, 1'b0, "or"},
         '{4'b0010, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_0FF0, 1'b0, 1'b0, "xor"},
         '{4'b0110, 32'h0000_0000, 32'h0000_1234, 32'h1234_0000, 1'b0, 1'b0, "lui"},
         '{4'b0011, 32'h0000_001F, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b0, "sll"},
         '{4'b0111, 32'h0000_0004, 32'h8000_0000, 32'h0800_0000, 1'b0, 1'b0, "srl"},
         '{4'b1111, 32'h0000_0004, 32'h8000_0000, 32'hF800_0000, 1'b0, 1'b0, "sra"},
         '{4'b1011, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0, "slt_true"},
         '{4'b1011, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, "slt_false"},
         '{4'b1010, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 1'b1, 1'b0, "xor_alt"},
         '{4'b0101, 32'h7FFF_FFFF, 32'h0000_0001, 32'h7FFF_FFFF, 1'b0, 1'b0, "or_no_v"}
      };
      mv = '{
         '{2'b00, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB, LAT_NORM, "mult_neg"},
         '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, LAT_NORM, "multu_max"},
         '{2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, LAT_NORM, "mult_minmin"},
         '{2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, LAT_NORM, "div_neg_a"},
         '{2'b10, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, LAT_NORM, "div_neg_b"},
         '{2'b11, 32'd100,       32'd7,        32'd2,        32'd14,       LAT_NORM, "divu"},
         '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, LAT_NORM, "div_min_m1"},
         '{2'b11, 32'd9,         32'd0,        32'd9,        32'hFFFF_FFFF, LAT_DZ,   "divu_zero"},
         '{2'b10, 32'hFFFF_FFFB, 32'd0,        32'hFFFF_FFFB, 32'hFFFF_FFFF, LAT_DZ,   "div_zero"}
      };

      reset = 1'b1;
      a = '0; b = '0; aluc = '0; md_start = 1'b0; md_op = '0;
      a16 = '0; b16 = '0; aluc16 = '0; md_start16 = 1'b0; md_op16 = '0;
      repeat (3) @(posedge clock);
      #1;
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_hi", 64'(hi), 64'd0);
      check("rst_lo", 64'(lo), 64'd0);
      @(negedge clock);
      reset = 1'b0;

      foreach (av[i]) begin
         @(negedge clock);
         aluc = av[i].op;
         a    = av[i].a;
         b    = av[i].b;
         #1;
         check({av[i].name, "_s"}, 64'(s), 64'(av[i].s));
         check({av[i].name, "_z"}, 64'(z), 64'(av[i].z));
         check({av[i].name, "_v"}, 64'(v), 64'(av[i].v));
      end

      @(negedge clock);
      aluc16 = 4'b0000;
      a16    = 16'h7FFF;
      b16    = 16'h0001;
      #1;
      check("w16_add_s", 64'(s16), 64'h8000);
      check("w16_add_z", 64'(z16), 64'd0);
      check("w16_add_v", 64'(v16), 64'd1);

      foreach (mv[i]) begin
         @(negedge clock);
         issue(mv[i].op, mv[i].a, mv[i].b, mv[i].hi, mv[i].lo, mv[i].lat, mv[i].name, 1'b1);
         check({mv[i].name, "_busy"}, 64'(busy), 64'd1);
         wait_drain(mv[i].name);
      end

      // start pulsed mid-RUN with different operands must be ignored
      @(negedge clock);
      issue(2'b01, 32'd3, 32'd5, 32'd0, 32'd15, LAT_NORM, "midrun", 1'b1);
      repeat (5) @(negedge clock);
      issue(2'b11, 32'd100, 32'd100, 32'd0, 32'd0, 0, "ignored", 1'b0);
      check("midrun_busy", 64'(busy), 64'd1);
      wait_drain("midrun");

      // second start issued in the done cycle of the first
      @(negedge clock);
      issue(2'b11, 32'd100, 32'd7, 32'd2, 32'd14, LAT_NORM, "b2b_first", 1'b1);
      begin : wait_first
         for (int i = 0; i < 60; i++) begin
            @(negedge clock);
            if (done) disable wait_first;
         end
      end
      if (!done) fail("b2b_first_timeout");
      else issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h1, LAT_NORM, "b2b_second", 1'b1);
      wait_drain("b2b");

      // reset in the middle of a MULT discards it
      @(negedge clock);
      issue(2'b00, 32'hFFFF_FFFD, 32'd7, 32'd0, 32'd0, 0, "aborted", 1'b0);
      repeat (9) @(negedge clock);
      reset = 1'b1;
      @(posedge clock);
      #1;
      check("abort_busy", 64'(busy), 64'd0);
      check("abort_done", 64'(done), 64'd0);
      check("abort_hi", 64'(hi), 64'd0);
      check("abort_lo", 64'(lo), 64'd0);
      @(negedge clock);
      reset = 1'b0;
      done_snap = n_done;
      repeat (45) @(negedge clock);
      check("abort_no_done", 64'(n_done), 64'(done_snap));

      // WIDTH=16 instance: MULTU 0xFFFF * 2
      @(negedge clock);
      md_op16    = 2'b01;
      a16        = 16'hFFFF;
      b16        = 16'h0002;
      md_start16 = 1'b1;
      @(posedge clock);
      #1;
      md_start16 = 1'b0;
      c0 = cyc;
      begin : wait_w16
         for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (done16) disable wait_w16;
         end
      end
      if (!done16) begin
         fail("w16_timeout");
      end else begin
         check("w16_cycle", 64'(cyc - c0), 64'd17);
         check("w16_hi", 64'(hi16), 64'h0001);
         check("w16_lo", 64'(lo16), 64'hFFFE);
      end

      repeat (2) @(negedge clock);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
